// File: rtl/ctrl_ula.sv
// Multi-cycle execution controller: fetches one instruction per handshake, reads an
// 8x16 register file, drives an external ULA, captures its result and writes it back.
module ctrl_ula #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_res,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          err,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [2:0] OPC_LDI = 3'b110;
  localparam logic [2:0] OPC_ILL = 3'b111;

  state_t        r_state;
  state_t        w_nextState;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_regs [NREGS];
  logic [DW-1:0] r_aluA;
  logic [DW-1:0] r_aluB;
  logic [2:0]    r_aluOp;
  logic [DW-1:0] r_result;

  logic [2:0]    w_opc;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs;
  logic [2:0]    w_rt;
  logic [9:0]    w_imm;
  logic          w_isAluOp;
  logic          w_accept;

  assign w_opc     = r_ir[15:13];
  assign w_rd      = r_ir[12:10];
  assign w_rs      = r_ir[9:7];
  assign w_rt      = r_ir[6:4];
  assign w_imm     = r_ir[9:0];
  assign w_isAluOp = (w_opc != OPC_LDI) && (w_opc != OPC_ILL);
  assign w_accept  = (r_state == IDLE) && instr_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (instr_valid) begin
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        if (w_opc == OPC_ILL) begin
          w_nextState = IDLE;
        end else if (w_opc == OPC_LDI) begin
          w_nextState = WB;
        end else begin
          w_nextState = EXEC;
        end
      end
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand reads in DECODE see the file before this instruction's own write in WB.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ir     <= '0;
      r_aluA   <= '0;
      r_aluB   <= '0;
      r_aluOp  <= '0;
      r_result <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_ir <= instr;
      end
      if (r_state == DECODE) begin
        if (w_isAluOp) begin
          r_aluA  <= r_regs[w_rs];
          r_aluB  <= r_regs[w_rt];
          r_aluOp <= w_opc;
        end else if (w_opc == OPC_LDI) begin
          r_result <= {{(DW-10){1'b0}}, w_imm};
        end
      end
      if (r_state == EXEC) begin
        r_result <= alu_res;
      end
      if (r_state == WB) begin
        r_regs[w_rd] <= r_result;
      end
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign done        = (r_state == WB);
  assign err         = (r_state == DECODE) && (w_opc == OPC_ILL);
  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_op      = r_aluOp;
  assign result      = r_result;
  assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_ctrl_ula.sv
// Bench for ctrl_ula: models the external ULA, keeps a transaction-level model of the
// controller, compares every cycle and adds hand-computed literal checks.
module tb_ctrl_ula;

  logic        clock;
  logic        resetn;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_res;
  logic        done;
  logic [15:0] result;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;
  logic checkOn = 1'b0;

  ctrl_ula dut (
    .clock       (clock),
    .resetn      (resetn),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_res     (alu_res),
    .done        (done),
    .result      (result),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  // External ULA: unsigned compare for SLT, shifts by the full B operand.
  function automatic logic [15:0] ulaFn(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return (a < b) ? 16'd1 : 16'd0;
      3'd4:    return a << b;
      3'd5:    return a >> b;
      default: return 16'd0;
    endcase
  endfunction

  assign alu_res = ulaFn(alu_op, alu_a, alu_b);

  // Transaction model: an accepted instruction occupies 3 (ALU), 2 (LDI) or 1 (illegal)
  // busy cycles; its effects land at fixed cycle offsets from the accept edge.
  logic [15:0] mregs [8];
  logic [15:0] mres, mA, mB, mVal, mOpA, mOpB;
  logic [2:0]  mAluOp, mOpc, mRd;
  int          mAge, mDur;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
      mres = 0; mA = 0; mB = 0; mAluOp = 0; mAge = 0; mDur = 0;
      mVal = 0; mOpA = 0; mOpB = 0; mOpc = 0; mRd = 0;
    end else begin
      if (mDur == 0) begin
        if (instr_valid) begin
          mOpc = instr[15:13];
          mRd  = instr[12:10];
          mOpA = mregs[instr[9:7]];
          mOpB = mregs[instr[6:4]];
          if (mOpc == 3'd7) begin
            mDur = 1;
          end else if (mOpc == 3'd6) begin
            mDur = 2;
            mVal = {6'd0, instr[9:0]};
          end else begin
            mDur = 3;
            mVal = ulaFn(mOpc, mOpA, mOpB);
          end
          mAge = 1;
        end
      end else if (mAge == mDur) begin
        if (mOpc != 3'd7) mregs[mRd] = mVal;
        mDur = 0;
        mAge = 0;
      end else begin
        mAge++;
      end
      if (mDur != 0) begin
        if (mOpc <= 3'd5 && mAge == 2) begin
          mA = mOpA; mB = mOpB; mAluOp = mOpc;
        end
        if (mOpc != 3'd7 && mAge == mDur) mres = mVal;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] aluInstr(input logic [2:0] opc, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [2:0] rt);
    return {opc, rd, rs, rt, 4'd0};
  endfunction

  task automatic applyStimulus(input logic [15:0] ins);
    int n = 0;
    @(negedge clock);
    #3;
    while (!instr_ready && n < 50) begin
      @(negedge clock);
      #3;
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", 16'(instr_ready), 16'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic waitFinish(output int k);
    k = 0;
    do begin
      @(negedge clock);
      #3;
      k++;
      dbg_addr = dbg_addr + 3'd1;
    end while (!done && !err && k < 20);
  endtask

  task automatic checkReg(input string name, input logic [2:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    checkOutput(name, dbg_data, exp);
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [9:0] imm);
    int k;
    applyStimulus({3'b110, rd, imm});
    waitFinish(k);
    checkOutput("ldi_latency", 16'(k), 16'd2);
  endtask

  task automatic aluOp(input string name, input logic [2:0] opc, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] exp);
    int k;
    applyStimulus(aluInstr(opc, rd, rs, rt));
    waitFinish(k);
    checkOutput({name, "_latency"}, 16'(k), 16'd3);
    checkOutput({name, "_result"}, result, exp);
    @(negedge clock);
    #3;
    checkReg({name, "_wb"}, rd, exp);
  endtask

  task automatic doOp(input string name, input logic [2:0] opc, input logic [9:0] a,
                      input logic [9:0] b, input logic [15:0] exp);
    ldi(3'd4, a);
    ldi(3'd5, b);
    aluOp(name, opc, 3'd6, 3'd4, 3'd5, exp);
  endtask

  initial begin
    resetn      = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'd0;
    dbg_addr    = 3'd0;
    fork
      begin
        forever begin
          @(negedge clock);
          #2;
          if (checkOn) begin
            checkOutput("cyc_ready", 16'(instr_ready), 16'(mDur == 0));
            checkOutput("cyc_done", 16'(done), 16'(mDur != 0 && mAge == mDur && mOpc != 3'd7));
            checkOutput("cyc_err", 16'(err), 16'(mDur != 0 && mAge == mDur && mOpc == 3'd7));
            checkOutput("cyc_result", result, mres);
            checkOutput("cyc_alu_a", alu_a, mA);
            checkOutput("cyc_alu_b", alu_b, mB);
            checkOutput("cyc_alu_op", 16'(alu_op), 16'(mAluOp));
            checkOutput("cyc_dbg", dbg_data, mregs[dbg_addr]);
          end
        end
      end
      begin
        int k;
        int lowCnt;
        longint t1, t2;
        // reset state
        repeat (2) @(negedge clock);
        checkOn = 1'b1;
        #3;
        checkOutput("rst_ready", 16'(instr_ready), 16'd1);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);
        checkOutput("rst_alu_op", 16'(alu_op), 16'd0);
        for (int i = 0; i < 8; i++) checkReg("rst_dbg", 3'(i), 16'd0);
        @(negedge clock);
        #3;
        resetn = 1'b1;

        // LDI, LDI, ADD
        ldi(3'd1, 10'd3);
        ldi(3'd2, 10'd4);
        aluOp("add", 3'd0, 3'd3, 3'd1, 3'd2, 16'h0007);
        checkOutput("add_alu_a", alu_a, 16'd3);
        checkOutput("add_alu_b", alu_b, 16'd4);
        checkOutput("add_alu_op", 16'(alu_op), 16'd0);

        // op sweep
        doOp("sub", 3'd1, 10'h00F, 10'h003, 16'h000C);
        doOp("or", 3'd2, 10'h00C, 10'h00A, 16'h000E);
        doOp("slt_gt", 3'd3, 10'd6, 10'd2, 16'h0000);
        doOp("slt_lt", 3'd3, 10'd3, 10'd4, 16'h0001);
        doOp("slt_eq", 3'd3, 10'd5, 10'd5, 16'h0000);
        doOp("sll", 3'd4, 10'd6, 10'd1, 16'h000C);
        doOp("srl", 3'd5, 10'h014, 10'd1, 16'h000A);
        doOp("sub_wrap", 3'd1, 10'd0, 10'd1, 16'hFFFF);
        doOp("sll_big", 3'd4, 10'd1, 10'd16, 16'h0000);

        // illegal opcode
        applyStimulus({3'b111, 3'd3, 10'h3FF});
        waitFinish(k);
        checkOutput("ill_latency", 16'(k), 16'd1);
        checkOutput("ill_err", 16'(err), 16'd1);
        checkOutput("ill_done", 16'(done), 16'd0);
        @(negedge clock);
        #3;
        checkOutput("ill_err_clear", 16'(err), 16'd0);
        checkOutput("ill_ready", 16'(instr_ready), 16'd1);
        checkReg("ill_r3_kept", 3'd3, 16'h0007);

        // instr_valid held high across two ADDs
        @(negedge clock);
        #3;
        instr = aluInstr(3'd0, 3'd7, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clock);
        t1 = $time;
        @(negedge clock);
        #3;
        instr = aluInstr(3'd0, 3'd1, 3'd1, 3'd7);
        lowCnt = 0;
        while (!instr_ready && lowCnt < 20) begin
          lowCnt++;
          @(negedge clock);
          #3;
        end
        checkOutput("held_ready_low", 16'(lowCnt), 16'd3);
        @(posedge clock);
        t2 = $time;
        #1;
        instr_valid = 1'b0;
        checkOutput("held_gap", 16'((t2 - t1) / 40), 16'd4);
        waitFinish(k);
        checkOutput("held_result", result, 16'h000A);
        @(negedge clock);
        #3;
        checkReg("held_r1", 3'd1, 16'h000A);
        checkReg("held_r7", 3'd7, 16'h0007);

        // reset during EXEC
        applyStimulus(aluInstr(3'd0, 3'd3, 3'd1, 3'd2));
        @(negedge clock);
        #3;
        @(negedge clock);
        #3;
        checkOutput("exec_alu_a", alu_a, 16'h000A);
        resetn = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 16'(instr_ready), 16'd1);
        checkOutput("mid_rst_done", 16'(done), 16'd0);
        checkOutput("mid_rst_alu_a", alu_a, 16'd0);
        checkOutput("mid_rst_result", result, 16'd0);
        repeat (2) begin
          @(negedge clock);
          #3;
          checkOutput("mid_rst_no_done", 16'(done), 16'd0);
        end
        for (int i = 0; i < 8; i++) checkReg("mid_rst_dbg", 3'(i), 16'd0);
        @(negedge clock);
        #3;
        resetn = 1'b1;
        ldi(3'd2, 10'h155);
        @(negedge clock);
        #3;
        checkReg("post_rst_ldi", 3'd2, 16'h0155);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
